// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: shadow scoreboard of in-flight destinations driving load-use stall,
// branch flush, memory freeze, registered EX forwarding selects and saturating event counters.
module hazard_fwd_unit #(
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = (STAGES > 2) ? $clog2(STAGES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_dest_idx,
  input  logic             id_reg_wr,
  input  logic             id_rd_mem,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze,
  output logic [SEL_W-1:0] ex_fwd_rs1_sel,
  output logic [SEL_W-1:0] ex_fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);
  logic [STAGES-1:0]      sb_v, sb_wr, sb_ld;
  logic [STAGES-1:0][4:0] sb_dest;
  logic [SEL_W-1:0]       sel1, sel2;
  logic                   lu1, lu2, hazard, issue, stall_ev, flush_ev;

  // Scanning from the oldest entry down leaves the youngest producer as the result.
  function automatic logic [SEL_W:0] search(input logic [4:0] r, input logic en);
    logic [SEL_W:0] res;
    res = '0;
    for (int k = STAGES - 1; k >= 0; k--)
      if (en && r != 5'd0 && sb_v[k] && sb_wr[k] && sb_dest[k] == r)
        res = {sb_ld[k] && (k + 1 < LOAD_READY), (k <= STAGES - 2) ? SEL_W'(k + 1) : SEL_W'(0)};
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    {lu1, sel1} = search(id_rs1_idx, id_valid && id_rs1_used);
    {lu2, sel2} = search(id_rs2_idx, id_valid && id_rs2_used);
  end

  assign hazard      = lu1 || lu2;
  assign freeze      = mem_busy;
  assign flush_if_id = !rst && br_taken && !mem_busy;
  assign flush_id_ex = flush_if_id;
  assign stall_id    = !rst && (mem_busy || (hazard && !br_taken));
  assign issue       = !mem_busy && !br_taken && !hazard;
  assign stall_ev    = hazard && !mem_busy && !br_taken;
  assign flush_ev    = br_taken && !mem_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v           <= '0;
      sb_wr          <= '0;
      sb_ld          <= '0;
      sb_dest        <= '0;
      ex_fwd_rs1_sel <= '0;
      ex_fwd_rs2_sel <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
      freeze_cnt     <= '0;
    end else begin
      if (!mem_busy) begin
        sb_v           <= {sb_v[STAGES-2:0], issue && id_valid};
        sb_wr          <= {sb_wr[STAGES-2:0], id_reg_wr};
        sb_ld          <= {sb_ld[STAGES-2:0], id_rd_mem};
        sb_dest        <= {sb_dest[STAGES-2:0], id_dest_idx};
        ex_fwd_rs1_sel <= issue ? sel1 : '0;
        ex_fwd_rs2_sel <= issue ? sel2 : '0;
      end
      stall_cnt  <= cnt_clr ? '0 : stall_ev ? sat_inc(stall_cnt) : stall_cnt;
      flush_cnt  <= cnt_clr ? '0 : flush_ev ? sat_inc(flush_cnt) : flush_cnt;
      freeze_cnt <= cnt_clr ? '0 : mem_busy ? sat_inc(freeze_cnt) : freeze_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vectors with hand-computed expectations (STAGES=3, LOAD_READY=2, CNT_W=4).
module tb_hazard_fwd_unit;
  logic       clk = 0, rst = 1;
  logic       id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_wr = 0, id_rd_mem = 0;
  logic [4:0] id_rs1_idx = 0, id_rs2_idx = 0, id_dest_idx = 0;
  logic       br_taken = 0, mem_busy = 0, cnt_clr = 0;
  logic       stall_id, flush_if_id, flush_id_ex, freeze;
  logic [1:0] ex_fwd_rs1_sel, ex_fwd_rs2_sel;
  logic [3:0] stall_cnt, flush_cnt, freeze_cnt;
  int n_chk = 0, n_fail = 0;

  hazard_fwd_unit #(.STAGES(3), .LOAD_READY(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_dest_idx(id_dest_idx), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
    .br_taken(br_taken), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .stall_id(stall_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze(freeze),
    .ex_fwd_rs1_sel(ex_fwd_rs1_sel), .ex_fwd_rs2_sel(ex_fwd_rs2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic [4:0] d, input logic w, input logic l);
    id_valid = v; id_rs1_idx = r1; id_rs1_used = u1; id_rs2_idx = r2; id_rs2_used = u2;
    id_dest_idx = d; id_reg_wr = w; id_rd_mem = l;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
  endtask

  initial begin
    #2;
    check("rst_stall", stall_id, 0);
    check("rst_flush", {flush_if_id, flush_id_ex}, 0);
    check("rst_sel", {ex_fwd_rs1_sel, ex_fwd_rs2_sel}, 0);
    check("rst_cnt", {stall_cnt, flush_cnt, freeze_cnt}, 0);
    #10 rst = 0;
    tick();
    // lw x5 ; add x6,x5,x1
    drv(1, 2, 1, 0, 0, 5, 1, 1);
    check("lw_nostall", stall_id, 0);
    tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0);
    check("lu_stall", stall_id, 1);
    tick();
    check("lu_bubble", dut.sb_v[0], 0);
    check("lu_sel_during", ex_fwd_rs1_sel, 0);
    check("lu_stall_done", stall_id, 0);
    tick();
    check("lu_sel1", ex_fwd_rs1_sel, 2);
    check("lu_sel2", ex_fwd_rs2_sel, 0);
    check("lu_cnt", stall_cnt, 1);
    idle(3);
    // add x5 ; sub x7,x5,x5
    drv(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    drv(1, 5, 1, 5, 1, 7, 1, 0);
    check("alu_nostall", stall_id, 0);
    tick();
    check("alu_sel", {ex_fwd_rs1_sel, ex_fwd_rs2_sel}, 4'b0101);
    idle(3);
    drv(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    drv(1, 3, 1, 4, 1, 9, 1, 0);
    tick();
    drv(1, 5, 1, 5, 1, 7, 1, 0);
    tick();
    check("gap_sel", {ex_fwd_rs1_sel, ex_fwd_rs2_sel}, 4'b1010);
    idle(3);
    // load into x0 then consumer of x0
    drv(1, 1, 1, 0, 0, 0, 1, 1);
    tick();
    drv(1, 0, 1, 0, 1, 8, 1, 0);
    check("x0_nostall", stall_id, 0);
    tick();
    check("x0_sel", {ex_fwd_rs1_sel, ex_fwd_rs2_sel}, 0);
    idle(3);
    // producer only in s[2]: register-file write-through
    drv(1, 1, 1, 0, 0, 5, 1, 0);
    tick();
    idle(2);
    drv(1, 5, 1, 0, 0, 7, 1, 0);
    check("s2_nostall", stall_id, 0);
    tick();
    check("s2_sel", ex_fwd_rs1_sel, 0);
    idle(3);
    clear();
    check("clr_stall_cnt", stall_cnt, 0);
    // branch taken together with a load-use hazard
    drv(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0);
    br_taken = 1;
    #1;
    check("br_stall", stall_id, 0);
    check("br_flush", {flush_if_id, flush_id_ex}, 2'b11);
    tick();
    br_taken = 0;
    check("br_s0", dut.sb_v[0], 0);
    check("br_s1", dut.sb_v[1], 1);
    check("br_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 0);
    idle(3);
    clear();
    // freeze during a pending load-use stall
    drv(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0);
    mem_busy = 1;
    br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_out", {freeze, stall_id, flush_if_id, flush_id_ex}, 4'b1100);
      tick();
    end
    mem_busy = 0;
    br_taken = 0;
    #1;
    check("frz_held_s0", dut.sb_v[0], 1);
    check("frz_cnt", freeze_cnt, 3);
    check("frz_stall_cnt", stall_cnt, 0);
    check("frz_flush_cnt", flush_cnt, 0);
    check("frz_release_stall", stall_id, 1);
    tick();
    check("frz_stall_cnt2", stall_cnt, 1);
    check("frz_stall_done", stall_id, 0);
    tick();
    check("frz_sel", ex_fwd_rs1_sel, 2);
    idle(3);
    clear();
    // 20 load-use stalls saturate a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drv(1, 2, 1, 0, 0, 5, 1, 1);
      tick();
      drv(1, 5, 1, 1, 1, 6, 1, 0);
      tick();
      tick();
    end
    check("sat_cnt", stall_cnt, 15);
    clear();
    check("sat_clr", stall_cnt, 0);
    // async reset in the middle of a stall
    drv(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0);
    tick();
    tick();
    drv(1, 2, 1, 0, 0, 5, 1, 1);
    tick();
    drv(1, 5, 1, 1, 1, 6, 1, 0);
    check("pre_rst_stall", stall_id, 1);
    check("pre_rst_cnt", stall_cnt, 1);
    mem_busy = 1;
    rst = 1;
    #1;
    check("arst_stall", stall_id, 0);
    check("arst_freeze", freeze, 1);
    check("arst_sb", dut.sb_v, 0);
    check("arst_cnt", {stall_cnt, flush_cnt, freeze_cnt}, 0);
    mem_busy = 0;
    #1;
    check("arst_stall2", stall_id, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. It keeps a shadow scoreboard of the destination registers of in-flight instructions for a configurable number of post-ID stages. From that scoreboard it drives the load-use stall, the branch flushes, the whole-pipe freeze on a busy data memory, and registered operand-forwarding selects for EX. It also keeps saturating performance counters. It sits beside the ID stage and drives the enables and flushes of the IF/ID and ID/EX registers, plus the EX operand muxes.

## Interface
- STAGES, default 3: number of tracked pipeline registers; s[0]=ID/EX … s[STAGES-1]=MEM/WB. Legal range 2..8.
- LOAD_READY, default 2: first scoreboard index whose register holds load data. Legal range 1..STAGES.
- CNT_W, default 16: performance counter width.
- SEL_W, derived: $clog2(STAGES), minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1_idx, id_rs2_idx  in  5  source register indices.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_dest_idx  in  5  destination register.
- id_reg_wr  in  1  the instruction writes the register file.
- id_rd_mem  in  1  the instruction is a load.
- br_taken  in  1  taken branch/jump resolved in EX this cycle.
- mem_busy  in  1  data memory not ready; the whole pipe must freeze.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_id  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush_if_id, flush_id_ex  out  1  squash the IF/ID / ID/EX contents.
- freeze  out  1  equals mem_busy; hold every pipeline register.
- ex_fwd_rs1_sel, ex_fwd_rs2_sel  out  SEL_W  registered. 0 = register-file value; k = result held in pipeline register s[k].
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W  saturating event counters.

## Operation
- Scoreboard entry s[k] holds {valid, dest, reg_wr, rd_mem}.
- An entry is a producer for a source index r when all of these hold: valid, reg_wr, dest==r, r!=0.
- Hazard search, done separately for rs1 and rs2 when rsN_used and id_valid:
  - Find j = the lowest k in 0..STAGES-1 whose entry is a producer.
  - If j ≤ STAGES-2: the candidate select is j+1.
  - If j = STAGES-1 or there is no match: the candidate select is 0. The register file must write through.
  - A load-use hazard exists when s[j].rd_mem and j+1 < LOAD_READY.
- Priority, highest first:
  - freeze: freeze=1, stall_id=1, no flushes. All scoreboard and select registers hold. br_taken is ignored; its producer holds it.
  - br_taken: flush_if_id=1, flush_id_ex=1, stall_id=0. Any hazard is discarded.
  - load-use hazard: stall_id=1.
  - otherwise: issue.
- Edge update when not frozen:
  - s[k] <= s[k-1] for k ≥ 1.
  - s[0] <= the ID instruction on issue; otherwise s[0] becomes a bubble (valid=0), covering both stall and flush.
  - ex_fwd_rsN_sel <= the candidate select on issue, otherwise 0.
- The branch itself (already in s[0]) advances normally on a flush.
- Counters, each saturating at 2^CNT_W-1:
  - stall_cnt increments on cycles with a load-use stall and no freeze or flush.
  - flush_cnt increments on br_taken cycles that are not frozen.
  - freeze_cnt increments on mem_busy cycles.
  - cnt_clr has priority over increment.

## Timing
- stall_id, flush_if_id, flush_id_ex and freeze are combinational from the inputs and the current scoreboard, valid within the same cycle.
- Forwarding selects have one-cycle latency. They are computed in ID, registered, and used in EX the following cycle.
- Load-use stall length is LOAD_READY-1-j cycles; 1 cycle for back-to-back with the default parameters.
- Reset (async, at any time, including mid-stall or mid-freeze):
  - all scoreboard valid=0;
  - selects=0;
  - counters=0;
  - combinational outputs = 0 except freeze, which follows mem_busy.
- Freeze for N cycles, then release: the state is identical to the state before the freeze, and the pending stall decision is re-evaluated.
- Simultaneous events:
  - br_taken with a hazard: flush wins.
  - mem_busy with anything: freeze wins.
  - cnt_clr with an event: the counter reads 0.

## Test plan
- lw x5 followed immediately by add x6,x5,x1 (defaults): stall_id=1 for exactly one cycle with s[0] bubbled; next cycle ex_fwd_rs1_sel=2, ex_fwd_rs2_sel=0; stall_cnt=1.
- add x5 then sub x7,x5,x5: no stall; next cycle both selects=1. Inserting one unrelated instruction between them gives selects=2.
- Producer with dest x0 followed by a consumer of x0: no stall, selects=0. Producer sitting only in s[2]: select=0 (register-file write-through path).
- br_taken in the same cycle as a load-use hazard: stall_id=0, both flushes=1, flush_cnt=1, s[0] valid=0 after the edge, branch entry present in s[1].
- mem_busy held 3 cycles during a pending load-use stall: all outputs and registers held, freeze_cnt=3, stall_cnt unchanged. After release the stall completes normally.
- CNT_W=4 with 20 stalls: stall_cnt=15. cnt_clr gives 0. Async rst mid-stall clears the scoreboard and counters immediately, without waiting for a clock edge.
